// File: rtl/acc_stim_compactor.sv
`default_nettype none
// ============================================================================
// Module : acc_stim_compactor
// Brief  : LFSR stimulus driver and MISR response compactor for the 3-bit
//          accumulator/overflow block.
// Rev    : 1.0  initial release
// ============================================================================
module acc_stim_compactor #(
    parameter int NB_DATA = 3,
    parameter int NB_SEL  = 2,
    parameter int NB_RES  = 6,
    parameter int NUM_OPS = 32,
    parameter int LAT     = 1
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [7:0]         i_seed,
    output logic [NB_DATA-1:0] o_data1,
    output logic [NB_DATA-1:0] o_data2,
    output logic [NB_SEL-1:0]  o_sel,
    output logic               o_dut_rst_n,
    input  logic [NB_RES-1:0]  i_data,
    input  logic               i_overflow,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_signature,
    output logic [7:0]         o_ovf_count,
    output logic [7:0]         o_op_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DUT_RST = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_d;
    logic [15:0]        sig_q;
    logic [15:0]        sig_d;
    logic [15:0]        resp_ext;
    logic [7:0]         ovf_q;
    logic [7:0]         ops_q;
    logic [LAT:0]       pipe_q;
    logic [NB_DATA-1:0] data1_q;
    logic [NB_DATA-1:0] data2_q;
    logic [NB_SEL-1:0]  sel_q;
    logic               dut_rst_n_q;
    logic               busy_q;
    logic               done_q;
    logic               issue;
    logic               capture;

    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign resp_ext = 16'({i_overflow, i_data});
    assign sig_d    = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ resp_ext;

    // First operand leaves on the same edge that releases the DUT reset.
    assign issue   = (state_q == S_DUT_RST && cnt_q == 3'd1) || (state_q == S_RUN);
    // pipe_q[0] marks operands currently on the bus; bit LAT marks the matching result.
    assign capture = pipe_q[LAT] && (state_q == S_RUN || state_q == S_DRAIN);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            lfsr_q      <= 8'd0;
            sig_q       <= 16'd0;
            ovf_q       <= 8'd0;
            ops_q       <= 8'd0;
            pipe_q      <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            sel_q       <= '0;
            dut_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pipe_q <= {pipe_q[LAT-1:0], issue};

            if (capture) begin
                sig_q <= sig_d;
                if (i_overflow && ovf_q != 8'hFF) begin
                    ovf_q <= ovf_q + 8'd1;
                end
            end

            if (issue) begin
                data1_q <= lfsr_q[NB_DATA-1:0];
                data2_q <= lfsr_q[2*NB_DATA-1:NB_DATA];
                sel_q   <= lfsr_q[2*NB_DATA +: NB_SEL];
                lfsr_q  <= lfsr_d;
                ops_q   <= ops_q + 8'd1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        lfsr_q      <= (i_seed == 8'h00) ? 8'hA5 : i_seed;
                        sig_q       <= 16'd0;
                        ovf_q       <= 8'd0;
                        ops_q       <= 8'd0;
                        cnt_q       <= 3'd0;
                        pipe_q      <= '0;
                        data1_q     <= '0;
                        data2_q     <= '0;
                        sel_q       <= '0;
                        dut_rst_n_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= S_DUT_RST;
                    end
                end
                S_DUT_RST: begin
                    if (cnt_q == 3'd1) begin
                        dut_rst_n_q <= 1'b1;
                        state_q     <= S_RUN;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_RUN: begin
                    if (ops_q == 8'(NUM_OPS - 1)) begin
                        cnt_q   <= 3'd0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    data1_q <= '0;
                    data2_q <= '0;
                    sel_q   <= '0;
                    if (cnt_q == 3'(LAT)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_data1     = data1_q;
    assign o_data2     = data2_q;
    assign o_sel       = sel_q;
    assign o_dut_rst_n = dut_rst_n_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_signature = sig_q;
    assign o_ovf_count = ovf_q;
    assign o_op_count  = ops_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_stim_compactor.sv
`default_nettype none
// ============================================================================
// Module : tb_acc_stim_compactor
// Brief  : Self-checking bench; a mock accumulator answers the driven operands.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_acc_stim_compactor;

    localparam int LAT     = 1;
    localparam int NUM_OPS = 32;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_seed;
    logic [2:0]  o_data1;
    logic [2:0]  o_data2;
    logic [1:0]  o_sel;
    logic        o_dut_rst_n;
    logic [5:0]  i_data;
    logic        i_overflow;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_signature;
    logic [7:0]  o_ovf_count;
    logic [7:0]  o_op_count;

    int          mode;      // 0: responses tied 0, 1: overflow tied 1, 2: functional mock
    logic [6:0]  mock_q;
    logic [7:0]  exp_ops[$];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    acc_stim_compactor #(
        .NB_DATA (3),
        .NB_SEL  (2),
        .NB_RES  (6),
        .NUM_OPS (NUM_OPS),
        .LAT     (LAT)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_seed      (i_seed),
        .o_data1     (o_data1),
        .o_data2     (o_data2),
        .o_sel       (o_sel),
        .o_dut_rst_n (o_dut_rst_n),
        .i_data      (i_data),
        .i_overflow  (i_overflow),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_signature (o_signature),
        .o_ovf_count (o_ovf_count),
        .o_op_count  (o_op_count)
    );

    function automatic logic [6:0] acc_model(input logic [2:0] a, input logic [2:0] b,
                                             input logic [1:0] s);
        logic [5:0] r;
        logic       ov;
        case (s)
            2'd0:    begin r = 6'(a) + 6'(b); ov = (r > 6'd7); end
            2'd1:    begin r = 6'(a) * 6'(b); ov = (r > 6'd7); end
            2'd2:    begin r = 6'(a) - 6'(b); ov = (b > a);    end
            default: begin r = {a, b};        ov = 1'b0;       end
        endcase
        return {ov, r};
    endfunction

    function automatic logic [7:0] next_lfsr(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Single-cycle-latency accumulator stand-in
    always @(posedge clk) begin
        if (!o_dut_rst_n) mock_q <= 7'd0;
        else              mock_q <= acc_model(o_data1, o_data2, o_sel);
    end

    assign i_data     = (mode == 0) ? 6'd0 : mock_q[5:0];
    assign i_overflow = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : mock_q[6];

    // Full run from start to DONE; every issued op is compared against the scoreboard.
    task automatic do_run(input logic [7:0] seed, input bit poke_start, output logic [15:0] sig_o,
                          output logic [7:0] ovf_o);
        logic [7:0]  l;
        logic [15:0] s;
        logic [7:0]  ov;
        logic [6:0]  r;
        logic        fb;
        logic [7:0]  op;
        int          n;
        l  = (seed == 8'h00) ? 8'hA5 : seed;
        s  = 16'd0;
        ov = 8'd0;
        exp_ops.delete();
        for (int k = 0; k < NUM_OPS; k++) begin
            exp_ops.push_back(l);
            r = (mode == 0) ? 7'd0 : acc_model(l[2:0], l[5:3], l[7:6]);
            if (mode == 1) r[6] = 1'b1;
            fb = s[15] ^ s[13] ^ s[12] ^ s[10];
            s  = {s[14:0], fb} ^ {9'd0, r};
            if (r[6] && ov != 8'hFF) ov = ov + 8'd1;
            l = next_lfsr(l);
        end

        i_seed = seed;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        n_total++;
        if ({o_busy, o_done, o_dut_rst_n} !== 3'b100)
            $display("FAIL start_flags: got busy/done/dut_rst_n=%b want 100", {o_busy, o_done, o_dut_rst_n});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (o_dut_rst_n !== 1'b0)
            $display("FAIL dut_rst_cycle2: got o_dut_rst_n=%b want 0", o_dut_rst_n);
        else n_pass++;

        for (int k = 0; k < NUM_OPS; k++) begin
            @(negedge clk);
            i_start = (poke_start && (k == 5)) ? 1'b1 : 1'b0;
            op = exp_ops.pop_front();
            n_total++;
            if ({o_dut_rst_n, o_op_count, o_sel, o_data2, o_data1} !== {1'b1, 8'(k + 1), op})
                $display("FAIL op%0d: got rst_n=%b cnt=%0d sel=%0d d2=%0d d1=%0d want rst_n=1 cnt=%0d sel=%0d d2=%0d d1=%0d",
                         k, o_dut_rst_n, o_op_count, o_sel, o_data2, o_data1, k + 1, op[7:6], op[5:3], op[2:0]);
            else n_pass++;
        end
        i_start = 1'b0;

        n = 0;
        while (!o_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n !== LAT + 1)
            $display("FAIL done_latency: got %0d cycles after last op want %0d", n, LAT + 1);
        else n_pass++;
        n_total++;
        if ({o_signature, o_ovf_count, o_op_count, o_busy} !== {s, ov, 8'(NUM_OPS), 1'b0})
            $display("FAIL results: got sig=%h ovf=%0d ops=%0d busy=%b want sig=%h ovf=%0d ops=%0d busy=0",
                     o_signature, o_ovf_count, o_op_count, o_busy, s, ov, NUM_OPS);
        else n_pass++;
        sig_o = o_signature;
        ovf_o = o_ovf_count;

        repeat (3) @(negedge clk);
        n_total++;
        if ({o_done, o_signature, o_ovf_count} !== {1'b1, s, ov})
            $display("FAIL hold_in_done: got done=%b sig=%h ovf=%0d want done=1 sig=%h ovf=%0d",
                     o_done, o_signature, o_ovf_count, s, ov);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_seed  = 8'h00;
        mode    = 0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({o_data1, o_data2, o_sel, o_dut_rst_n, o_busy, o_done, o_signature, o_ovf_count, o_op_count} !== 43'd0)
            $display("FAIL reset_outputs: got sig=%h ovf=%0d ops=%0d busy=%b done=%b rst_n=%b want all 0",
                     o_signature, o_ovf_count, o_op_count, o_busy, o_done, o_dut_rst_n);
        else n_pass++;
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({o_busy, o_done, o_dut_rst_n} !== 3'b000)
            $display("FAIL idle_after_reset: got busy/done/dut_rst_n=%b want 000", {o_busy, o_done, o_dut_rst_n});
        else n_pass++;
    endtask

    task automatic test_seed01();
        logic [15:0] sig;
        logic [7:0]  ovf;
        mode = 2;
        do_run(8'h01, 1'b0, sig, ovf);
    endtask

    task automatic test_zero_seed();
        logic [15:0] sig_a, sig_b;
        logic [7:0]  ovf;
        mode = 2;
        do_run(8'h00, 1'b0, sig_a, ovf);
        do_run(8'hA5, 1'b0, sig_b, ovf);
        n_total++;
        if (sig_a !== sig_b)
            $display("FAIL zero_seed_sig: got seed00 sig=%h want seedA5 sig=%h", sig_a, sig_b);
        else n_pass++;
    endtask

    task automatic test_tied_zero();
        logic [15:0] sig;
        logic [7:0]  ovf;
        mode = 0;
        do_run(8'h5A, 1'b0, sig, ovf);
        n_total++;
        if ({sig, ovf} !== 24'd0)
            $display("FAIL tied_zero: got sig=%h ovf=%0d want sig=0000 ovf=0", sig, ovf);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] sig_a, sig_b;
        logic [7:0]  ovf;
        mode = 1;
        do_run(8'h3C, 1'b1, sig_a, ovf);
        n_total++;
        if (ovf !== 8'd32)
            $display("FAIL ovf_tied_one: got ovf=%0d want 32", ovf);
        else n_pass++;
        do_run(8'h3C, 1'b1, sig_b, ovf);
        n_total++;
        if (sig_b !== sig_a)
            $display("FAIL rerun_sig: got sig=%h want %h", sig_b, sig_a);
        else n_pass++;
    endtask

    task automatic test_mid_run_reset();
        logic [15:0] sig;
        logic [7:0]  ovf;
        int          n;
        mode   = 2;
        i_seed = 8'h77;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        n = 0;
        while (o_op_count != 8'd10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= 50)
            $display("FAIL reach_op10: got op_count=%0d want 10 within 50 cycles", o_op_count);
        else n_pass++;
        i_rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_data1, o_data2, o_sel, o_dut_rst_n, o_busy, o_done, o_signature, o_ovf_count, o_op_count} !== 43'd0)
            $display("FAIL midrun_reset: got sig=%h ovf=%0d ops=%0d busy=%b rst_n=%b want all 0",
                     o_signature, o_ovf_count, o_op_count, o_busy, o_dut_rst_n);
        else n_pass++;
        @(negedge clk) i_rst_n = 1'b1;
        do_run(8'h77, 1'b0, sig, ovf);
    endtask

    initial begin
        test_reset();
        test_seed01();
        test_zero_seed();
        test_tied_zero();
        test_back_to_back();
        test_mid_run_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
